// File: rtl/weight_tx.sv
// ============================================================================
// weight_tx : weight-load transmitter; streams wordlines into per-core SRAMs
// Rev 1.0
// ============================================================================
`default_nettype none

module weight_tx #(
  parameter int WORD_W    = 256,
  parameter int ADDR_W    = 10,
  parameter int NUM_CORES = 4,
  parameter int LEN_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_base_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic [NUM_CORES-1:0] cmd_core_mask,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WORD_W-1:0]    s_data,
  output logic [WORD_W-1:0]    rx_out,
  output logic [ADDR_W-1:0]    weight_addr_out,
  output logic [NUM_CORES-1:0] weight_we_out,
  output logic [NUM_CORES-1:0] weight_me_out,
  output logic                 weight_oe_out,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_W-1:0]     words_sent
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state_q,      state_d;
  logic [ADDR_W-1:0]    cur_addr_q,   cur_addr_d;
  logic [LEN_W-1:0]     remaining_q,  remaining_d;
  logic [NUM_CORES-1:0] mask_q,       mask_d;
  logic [WORD_W-1:0]    rx_q,         rx_d;
  logic [ADDR_W-1:0]    waddr_q,      waddr_d;
  logic [NUM_CORES-1:0] strobe_q,     strobe_d;
  logic [LEN_W-1:0]     words_sent_q, words_sent_d;

  logic cmd_fire;
  logic s_fire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          state_d = (cmd_len != '0) ? S_XFER : S_DONE;
        end
      end
      S_XFER: begin
        if (s_fire && (remaining_q == LEN_W'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; cmd_ready is gated by rst so it stays low throughout reset
  always_comb begin
    cmd_ready = (state_q == S_IDLE) && !rst;
    s_ready   = (state_q == S_XFER);
    busy      = (state_q == S_XFER) || (state_q == S_DONE);
    done      = (state_q == S_DONE);
  end

  assign cmd_fire = cmd_valid & cmd_ready;
  assign s_fire   = s_valid & s_ready;

  // Datapath next values; strobes are single-cycle, data/address hold
  always_comb begin
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    mask_d       = mask_q;
    rx_d         = rx_q;
    waddr_d      = waddr_q;
    strobe_d     = '0;
    words_sent_d = words_sent_q;

    if (cmd_fire) begin
      cur_addr_d   = cmd_base_addr;
      remaining_d  = cmd_len;
      mask_d       = cmd_core_mask;
      words_sent_d = '0;
    end

    if (s_fire) begin
      rx_d         = s_data;
      waddr_d      = cur_addr_q;
      strobe_d     = mask_q;
      cur_addr_d   = cur_addr_q + ADDR_W'(1);
      remaining_d  = remaining_q - LEN_W'(1);
      words_sent_d = words_sent_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      mask_q       <= '0;
      rx_q         <= '0;
      waddr_q      <= '0;
      strobe_q     <= '0;
      words_sent_q <= '0;
    end else begin
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      mask_q       <= mask_d;
      rx_q         <= rx_d;
      waddr_q      <= waddr_d;
      strobe_q     <= strobe_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign rx_out          = rx_q;
  assign weight_addr_out = waddr_q;
  assign weight_we_out   = strobe_q;
  assign weight_me_out   = strobe_q;
  assign weight_oe_out   = 1'b0;
  assign words_sent      = words_sent_q;

endmodule

`default_nettype wire
